// File: rtl/spart_tx_if.sv
// -----------------------------------------------------------------------------
// spart_tx_if
//
// Purpose: groups the processor-side transmit handshake of the SPART transmitter
// into one bundle.
//
// Signals:
//   tx_wr    write strobe, one clk cycle (master -> slave)
//   tx_data  byte to send, valid while tx_wr is high (master -> slave)
//   tbr      transmit buffer ready, holding register empty (slave -> master)
//   tx_busy  a frame is being shifted out (slave -> master)
//
// Modports:
//   master  processor / bus decode side
//   slave   spart_tx
// -----------------------------------------------------------------------------
interface spart_tx_if;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tbr;
    logic       tx_busy;

    modport master (
        output tx_wr,
        output tx_data,
        input  tbr,
        input  tx_busy
    );

    modport slave (
        input  tx_wr,
        input  tx_data,
        output tbr,
        output tx_busy
    );
endinterface

// File: rtl/spart_tx.sv
// -----------------------------------------------------------------------------
// spart_tx
//
// Purpose: transmit half of the SPART serial port. A one-entry holding register
// accepts bytes from the bus. A shifter sends them on txd as 8N1 frames:
// one start bit, eight data bits LSB first, one stop bit. One bit lasts
// OVS * (divisor + 1) clk cycles. When the next byte is already held at the
// end of a stop bit, the next start bit follows with no idle gap.
//
// Optional feature: define SPART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Each frame is then 11 bits long.
//
// Parameters:
//   DIV_W  width of the baud divisor (default 16)
//   OVS    baud enables per bit (default 16; the bit counter is 4 bits wide)
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   bus      spart_tx_if.slave: tx_wr/tx_data in, tbr/tx_busy out
//   divisor  baud divisor; the baud enable fires every divisor+1 cycles
//   txd      registered serial output, idles high
// -----------------------------------------------------------------------------
module spart_tx #(
    parameter int DIV_W = 16,
    parameter int OVS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    spart_tx_if.slave        bus,
    input  logic [DIV_W-1:0] divisor,
    output logic             txd
);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [3:0]       BIT_LAST = 4'(OVS - 1);
    localparam logic [DIV_W-1:0] BAUD_ONE = DIV_W'(1);

    state_t           state_q;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       hold_q;
    logic             tbr_q;
    logic             busy_q;
    logic             txd_q;
`ifdef SPART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic baud_en;
    logic bit_end;
    logic hold_full;
    logic wr_accept;
    logic start_frame;

    assign baud_en   = (baud_cnt_q == '0);
    assign bit_end   = baud_en && (bit_cnt_q == BIT_LAST);
    assign hold_full = ~tbr_q;
    // A write on the same edge as a holding-to-shifter transfer sees tbr_q==0
    // and is dropped.
    assign wr_accept = bus.tx_wr & tbr_q;
    // A frame starts from IDLE, or straight out of a finished stop bit.
    assign start_frame = hold_full &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // Baud and bit counters. The baud counter is reloaded whenever a frame
    // starts, so the start bit is full length. divisor is sampled only at a
    // reload, so a change takes effect at the next reload.
    always_comb begin
        baud_cnt_d = baud_cnt_q - BAUD_ONE;
        if (start_frame || baud_en) begin
            baud_cnt_d = divisor;
        end

        bit_cnt_d = bit_cnt_q;
        if (start_frame || (state_q == IDLE) || bit_end) begin
            bit_cnt_d = '0;
        end else if (baud_en) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Holding register capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (wr_accept) begin
            hold_q <= bus.tx_data;
        end
    end

    // Frame state machine. txd, tx_busy and tbr are registered here. Each
    // output takes the value of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shift_q  <= '0;
            tbr_q    <= 1'b1;
            busy_q   <= 1'b0;
            txd_q    <= 1'b1;
`ifdef SPART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (wr_accept) begin
                tbr_q <= 1'b0;
            end

            // Holding -> shifter transfer; shared by IDLE and the end of STOP.
            if (start_frame) begin
                shift_q  <= hold_q;
                tbr_q    <= 1'b1;
                state_q  <= START;
                busy_q   <= 1'b1;
                txd_q    <= 1'b0;
`ifdef SPART_TX_PARITY_EN
                parity_q <= ^hold_q;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            txd_q   <= shift_q[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            idx_q   <= idx_q + 3'd1;
                            if (idx_q == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                                state_q <= PARITY;
                                txd_q   <= parity_q;
`else
                                state_q <= STOP;
                                txd_q   <= 1'b1;
`endif
                            end else begin
                                // The next data bit is the one about to shift into bit 0.
                                txd_q <= shift_q[1];
                            end
                        end
                    end
`ifdef SPART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        // A full holding register is handled by start_frame above.
                        if (bit_end) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            txd_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tbr     = tbr_q;
    assign bus.tx_busy = busy_q;
    assign txd         = txd_q;

endmodule

// File: tb/tb_spart_tx.sv
// -----------------------------------------------------------------------------
// tb_spart_tx
//
// Self-checking bench for spart_tx. Accepted writes push an expected frame
// (bit values plus bit period) onto a scoreboard queue. A monitor pops a frame
// at every start bit and checks each bit cycle by cycle. The directed steps
// cover reset values, frame timing, back-to-back frames, dropped writes,
// divisor changes and reset in the middle of a frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          period;
        logic [7:0]  data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] divisor;
    logic        txd;

    spart_tx_if bus();

    spart_tx #(.DIV_W(16), .OVS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .divisor (divisor),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;
    frame_t sb_q[$];
    frame_t mon_f;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
        $display("[TB] check %s observed=%0d required=%0d", tag, obs, expv);
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input int period);
        frame_t f;
        f.data    = d;
        f.period  = period;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
`ifdef SPART_TX_PARITY_EN
        f.bits[9]  = ^d;
        f.bits[10] = 1'b1;
        f.nbits    = 11;
`else
        f.bits[9]  = 1'b1;
        f.nbits    = 10;
`endif
        return f;
    endfunction

    // Called at a negedge. Drives one write strobe and returns at the next negedge.
    task automatic do_write(input logic [7:0] d, input bit expect_acc);
        bus.tx_wr   = 1'b1;
        bus.tx_data = d;
        if (expect_acc) sb_q.push_back(make_frame(d, 16 * (int'(divisor) + 1)));
        @(negedge clk);
        bus.tx_wr   = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag);
        int w = 0;
        while (bus.tx_busy !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, bus.tx_busy, 0);
    endtask

    task automatic wait_fall(input string tag);
        int w = 0;
        while (txd !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(tag, txd, 0);
    endtask

    // Counts cycles while txd keeps its current value; returns at the first
    // negedge of the next run.
    task automatic measure_run(output int n);
        logic v;
        v = txd;
        n = 0;
        while (txd === v && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor: each start bit pops one expected frame.
    initial begin : monitor
        int bad;
        int w;
        @(negedge clk);
        forever begin
            if (mon_en && rst === 1'b0 && txd === 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    w = 0;
                    while (txd === 1'b0 && w < 1000) begin
                        @(negedge clk);
                        w++;
                    end
                end else begin
                    mon_f = sb_q.pop_front();
                    for (int k = 0; k < mon_f.nbits; k++) begin
                        bad = 0;
                        for (int c = 0; c < mon_f.period; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (txd !== mon_f.bits[k]) bad++;
                        end
                        chk($sformatf("frame_%02h_bit%0d_bad_cycles", mon_f.data, k), bad, 0);
                    end
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cnt;
        int run;

        rst         = 1'b1;
        bus.tx_wr   = 1'b0;
        bus.tx_data = 8'h00;
        divisor     = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_tbr", bus.tbr, 1);
        chk("reset_busy", bus.tx_busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // ---- single frame, divisor 0 ----
        do_write(8'hA5, 1'b1);
        chk("single_tbr_after_e0", bus.tbr, 0);
        chk("single_busy_after_e0", bus.tx_busy, 0);
        @(negedge clk);
        chk("single_tbr_after_e1", bus.tbr, 1);
        chk("single_busy_after_e1", bus.tx_busy, 1);
        chk("single_txd_after_e1", txd, 0);
        cnt = 0;
        while (bus.tx_busy === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk("single_busy_cycles", cnt, 16 * NB);
        repeat (20) @(negedge clk);
        chk("single_queue_empty", sb_q.size(), 0);

        // ---- back-to-back, divisor 3 ----
        divisor = 16'd3;
        do_write(8'h55, 1'b1);
        cnt = 0;
        while (bus.tbr !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_tbr_rise", bus.tbr, 1);
        do_write(8'h0F, 1'b1);
        // The negedge after the first start edge is already past, so one busy cycle is not counted here.
        cnt = 0;
        while (bus.tx_busy === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk("b2b_busy_contiguous", cnt, 2 * NB * 64 - 1);
        repeat (20) @(negedge clk);
        chk("b2b_queue_empty", sb_q.size(), 0);

        // ---- dropped write, divisor 0 ----
        divisor = 16'd0;
        do_write(8'h11, 1'b1);
        chk("drop_tbr_low", bus.tbr, 0);
        do_write(8'h22, 1'b0);   // lands on the transfer edge
        chk("drop_tbr_after_transfer", bus.tbr, 1);
        wait_busy_low("drop_frame_done");
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b0) cnt++;
        end
        chk("drop_no_second_frame", cnt, 0);
        chk("drop_queue_empty", sb_q.size(), 0);

        // ---- divisor change during data bit 3 ----
        mon_en  = 1'b0;
        divisor = 16'd0;
        do_write(8'h55, 1'b0);
        wait_fall("divchg_start");
        measure_run(run); chk("divchg_start_len", run, 16);
        measure_run(run); chk("divchg_d0_len", run, 16);
        measure_run(run); chk("divchg_d1_len", run, 16);
        measure_run(run); chk("divchg_d2_len", run, 16);
        repeat (8) @(negedge clk);
        divisor = 16'd1;
        measure_run(run);        // d3: mixed timing, not checked
        measure_run(run); chk("divchg_d4_len", run, 32);
        measure_run(run); chk("divchg_d5_len", run, 32);
        measure_run(run); chk("divchg_d6_len", run, 32);
`ifndef SPART_TX_PARITY_EN
        measure_run(run); chk("divchg_d7_len", run, 32);
`endif
        wait_busy_low("divchg_frame_done");
        divisor = 16'd0;
        repeat (5) @(negedge clk);

        // ---- reset during data bit 4 ----
        do_write(8'h00, 1'b0);
        wait_fall("rstmid_start");
        repeat (5 * 16 + 8) @(negedge clk);
        chk("rstmid_txd_before", txd, 0);
        chk("rstmid_busy_before", bus.tx_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_txd_async", txd, 1);
        chk("rstmid_tbr_async", bus.tbr, 1);
        chk("rstmid_busy_async", bus.tx_busy, 0);
        repeat (5) @(negedge clk);
        chk("rstmid_txd_hold", txd, 1);
        chk("rstmid_tbr_hold", bus.tbr, 1);
        chk("rstmid_busy_hold", bus.tx_busy, 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || bus.tx_busy !== 1'b0) cnt++;
        end
        chk("rstmid_no_resume", cnt, 0);

        chk("final_queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_tx.md
# spart_tx

Transmit half of the SPART serial port. Accepts bytes written by the processor-side bus logic into a one-entry holding register and serializes them on `txd` as 8N1 frames: one start bit, eight data bits LSB first, one stop bit. The bit period is set by the shared 16-bit baud divisor. `tbr` tells the processor when another byte can be written, which allows back-to-back frames with no idle gap.

## Interface
- `DIV_W`, default 16: width of the baud divisor.
- `OVS`, default 16: baud enables per bit (oversampling ratio, matches the receiver).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous and active-high; all state clears immediately on assertion.
- `tx_wr`  in  1  write strobe, one `clk` cycle (decoded `iocs & ~iorw & ioaddr==2'b00`).
- `tx_data`  in  8  byte to send; sampled on the cycle `tx_wr` is high.
- `divisor`  in  DIV_W  baud divisor; the baud enable fires every `divisor+1` cycles.
- `tbr`  out  1  transmit buffer ready: holding register empty.
- `tx_busy`  out  1  a frame is being shifted out.
- `txd`  out  1  serial output; idles high.

## Operation
- Baud counter:
  - Down-counter loaded with `divisor`; pulses `baud_en` when it reaches 0, then reloads.
  - `divisor` is sampled only at reload.
  - Counter is forced to reload whenever a frame starts, so the start bit is full length.
- Bit counter:
  - 4-bit count of `baud_en` pulses; a bit ends at the `OVS`-th pulse.
  - Bit period is exactly `OVS*(divisor+1)` cycles.
- Holding register:
  - A write with `tbr==1` captures `tx_data` and clears `tbr`.
  - A write with `tbr==0` is dropped; the holding contents are unchanged.
- State machine (`IDLE`, `START`, `DATA`, `STOP`):
  - `IDLE`: `txd=1`. If the holding register is full, load it into the 8-bit shifter, set `tbr=1`, and go to `START`.
  - `START`: `txd=0` for one bit, then go to `DATA` with the bit index at 0.
  - `DATA`: `txd=shifter[0]`. At each bit end, shift right and increment the index. After bit 7, go to `STOP`.
  - `STOP`: `txd=1` for one bit. At the bit end, if the holding register is full, reload the shifter, set `tbr=1`, and go to `START` on the same edge. Otherwise go to `IDLE`.
- `tx_busy` is 1 in every state except `IDLE`.
- `txd` is registered, so it never glitches.

## Timing
- Reset values: `tbr=1`, `tx_busy=0`, `txd=1`, state `IDLE`, all counters 0, shifter and holding register 0.
- Latency (write accepted at edge E0):
  - After E0: `tbr=0`.
  - After E1: state `START`, `txd=0`, `tbr=1`, `tx_busy=1`.
- Frame length: 10 bit periods from the falling `txd` edge to the end of the stop bit.
- Back-to-back: with the next byte already written, the next start bit begins in the cycle right after the last stop-bit cycle. No idle cycles between frames.
- Simultaneous events:
  - `tx_wr` on the same edge as a holding-to-shifter transfer is dropped, because `tbr` is still 0 in that cycle.
  - `tx_wr` in the cycle after the transfer is accepted.
- Reset mid-frame: `txd` returns to 1 immediately. The partial frame is abandoned and not resent.
- `divisor` change mid-frame: takes effect at the next baud-counter reload. The bit counter is not affected.

## Configuration
- `SPART_TX_PARITY_EN`:
  - Defined: adds a `PARITY` state between `DATA` and `STOP` that sends even parity (XOR of the 8 data bits). Frame is 11 bit periods.
  - Undefined: no parity logic; 8N1 frames of 10 bit periods.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `txd=1`, `tbr=1`, `tx_busy=0` before the next `clk` edge. Hold `rst` for 5 cycles -> outputs unchanged.
- Single frame, `divisor=0`: write 0xA5 -> `tbr` low for exactly 1 cycle.
  - `txd` sequence: 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles.
  - `tx_busy` high for 160 cycles.
  - With `SPART_TX_PARITY_EN`: parity bit 0 inserted before the stop bit; `tx_busy` high for 176 cycles.
- Back-to-back, `divisor=3`: write 0x55, then write 0x0F as soon as `tbr` rises.
  - Second start bit directly follows the first stop bit with no gap.
  - Each bit lasts 64 cycles.
- Dropped write: write 0x11, then write 0x22 while `tbr=0` -> only the 0x11 frame appears; no second frame.
- Divisor change: change `divisor` from 0 to 1 during data bit 3 -> bits before the change last 16 cycles, bits after it last 32 cycles. The transition bit (mixed timing) is not checked.
- Reset mid-frame: assert `rst` during data bit 4 -> `txd=1` at once. After release, `IDLE` with no resumed frame.
